// File: rtl/issue_pkg.sv
// Shared types for the integer issue queue.
//   ctrl_t      : decoded control bundle, bit order matches the dispatch port
//                 {branch, jal, alu_src1, alu_src2, alu_op[1:0], load, store}
//   iq_entry_t  : per-entry control/readiness state. Tags and payload widths
//                 are module parameters, so they live in parallel arrays
//                 inside the queue rather than in this struct.
//   TAG_X0      : physical tag hard-wired to x0 (always ready, never broadcast)
package issue_pkg;

    localparam int unsigned TAG_X0 = 0;

    typedef struct packed {
        logic       branch;
        logic       jal;
        logic       alu_src1;
        logic       alu_src2;
        logic [1:0] alu_op;
        logic       load;
        logic       store;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  rs1_used;
        logic  rs2_used;
        logic  rdy1;
        logic  rdy2;
    } iq_entry_t;

    // Readiness of a source at dispatch: not needed, already in the register
    // file, reads x0, or being broadcast on the CDB in this very cycle.
    function automatic logic src_ready_at_capture(
        input logic used,
        input logic rf_rdy,
        input logic is_x0,
        input logic cdb_match
    );
        return !used || rf_rdy || is_x0 || cdb_match;
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Lowest-index-first priority encoder.
//   req   : request vector, bit 0 has highest priority (oldest entry)
//   grant : one-hot grant of the lowest set request bit (all zero if none)
//   idx   : binary index of the granted bit (0 when nothing is found)
//   found : at least one request bit is set
module iq_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + DEPTH'(1));
    assign found = |req;

    always_comb begin
        idx = '0;
        // Scan from the top so the lowest set index wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing reservation station between decode and the integer ALU/AGU.
// Entries [0 .. occupancy-1] are valid with index 0 the oldest. Sources wake
// up by snooping the CDB; each cycle the oldest entry with all needed sources
// ready is presented on issue_*. Issuing removes that entry and shifts all
// younger entries down one slot; flush empties the queue.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 squash all entries (dominates dispatch and issue)
//   disp_*                dispatch request / control / tags / payload
//   disp_ready            occupancy < DEPTH
//   cdb_valid, cdb_tag    result broadcast (tag 0 ignored)
//   issue_*               selected micro-op, issue_valid/issue_ready handshake
//   occupancy             number of valid entries
module issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6,
    parameter int PAY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [7:0]                 disp_ctrl,
    input  logic                       disp_rs1_used,
    input  logic                       disp_rs2_used,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic                       disp_src1_rdy,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_dst_tag,
    input  logic [PAY_W-1:0]           disp_payload,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [7:0]                 issue_ctrl,
    output logic [TAG_W-1:0]           issue_src1_tag,
    output logic [TAG_W-1:0]           issue_src2_tag,
    output logic [TAG_W-1:0]           issue_dst_tag,
    output logic [PAY_W-1:0]           issue_payload,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // State. Entry validity is implied by occupancy (the queue is always
    // compacted), so occ_reg is the only state that needs a reset.
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] occ_reg, occ_next;

    iq_entry_t        meta_reg     [DEPTH];
    logic [TAG_W-1:0] src1_tag_reg [DEPTH];
    logic [TAG_W-1:0] src2_tag_reg [DEPTH];
    logic [TAG_W-1:0] dst_tag_reg  [DEPTH];
    logic [PAY_W-1:0] payload_reg  [DEPTH];

    iq_entry_t        meta_next     [DEPTH];
    logic [TAG_W-1:0] src1_tag_next [DEPTH];
    logic [TAG_W-1:0] src2_tag_next [DEPTH];
    logic [TAG_W-1:0] dst_tag_next  [DEPTH];
    logic [PAY_W-1:0] payload_next  [DEPTH];

    // Entry state after this cycle's CDB wakeup has been applied.
    iq_entry_t        meta_woke [DEPTH];

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] req_vec;
    logic [DEPTH-1:0] grant_vec;
    logic [IDX_W-1:0] issue_idx;
    logic             issue_found;
    logic             issue_fire;
    logic             disp_fire;
    logic             cdb_live;
    logic [OCC_W-1:0] wr_idx;
    iq_entry_t        disp_entry;

    assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_X0));

    // ------------------------------------------------------------------
    // Per-entry wakeup and request generation.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign valid_vec[gi] = (OCC_W'(gi) < occ_reg);

        // Select looks only at registered readiness, which gives the
        // one-cycle wakeup-to-issue latency.
        assign req_vec[gi] = valid_vec[gi] && meta_reg[gi].rdy1 && meta_reg[gi].rdy2;

        always_comb begin
            meta_woke[gi] = meta_reg[gi];
            if (cdb_live && meta_reg[gi].rs1_used && (src1_tag_reg[gi] == cdb_tag)) begin
                meta_woke[gi].rdy1 = 1'b1;
            end
            if (cdb_live && meta_reg[gi].rs2_used && (src2_tag_reg[gi] == cdb_tag)) begin
                meta_woke[gi].rdy2 = 1'b1;
            end
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req   (req_vec),
        .grant (grant_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // ------------------------------------------------------------------
    // Handshakes.
    // ------------------------------------------------------------------
    assign issue_valid = issue_found && !flush;
    assign issue_fire  = issue_valid && issue_ready;

    // disp_ready ignores a same-cycle issue so it has no path from
    // issue_ready; a full queue therefore stalls dispatch for one cycle.
    assign disp_ready  = (occ_reg < OCC_W'(DEPTH));
    assign disp_fire   = disp_valid && disp_ready && !flush;

    // With a same-cycle issue the queue collapses by one, so the new entry
    // lands one slot lower.
    assign wr_idx = occ_reg - OCC_W'(issue_fire);

    always_comb begin
        disp_entry          = '0;
        disp_entry.ctrl     = ctrl_t'(disp_ctrl);
        disp_entry.rs1_used = disp_rs1_used;
        disp_entry.rs2_used = disp_rs2_used;
        disp_entry.rdy1     = src_ready_at_capture(disp_rs1_used, disp_src1_rdy,
                                                   disp_src1_tag == TAG_W'(TAG_X0),
                                                   cdb_valid && (cdb_tag == disp_src1_tag));
        disp_entry.rdy2     = src_ready_at_capture(disp_rs2_used, disp_src2_rdy,
                                                   disp_src2_tag == TAG_W'(TAG_X0),
                                                   cdb_valid && (cdb_tag == disp_src2_tag));
    end

    // ------------------------------------------------------------------
    // Next entry contents: hold (with wakeup), shift down above the issued
    // slot, then overlay the dispatched entry.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            meta_next[i]     = meta_woke[i];
            src1_tag_next[i] = src1_tag_reg[i];
            src2_tag_next[i] = src2_tag_reg[i];
            dst_tag_next[i]  = dst_tag_reg[i];
            payload_next[i]  = payload_reg[i];

            if (issue_fire && (IDX_W'(i) >= issue_idx) && (i < DEPTH - 1)) begin
                meta_next[i]     = meta_woke[i + 1];
                src1_tag_next[i] = src1_tag_reg[i + 1];
                src2_tag_next[i] = src2_tag_reg[i + 1];
                dst_tag_next[i]  = dst_tag_reg[i + 1];
                payload_next[i]  = payload_reg[i + 1];
            end

            if (disp_fire && (wr_idx == OCC_W'(i))) begin
                meta_next[i]     = disp_entry;
                src1_tag_next[i] = disp_src1_tag;
                src2_tag_next[i] = disp_src2_tag;
                dst_tag_next[i]  = disp_dst_tag;
                payload_next[i]  = disp_payload;
            end
        end
    end

    always_comb begin
        occ_next = occ_reg;
        if (flush) begin
            occ_next = '0;
        end else begin
            occ_next = occ_reg + OCC_W'(disp_fire) - OCC_W'(issue_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    // Entry payload is don't-care outside [0 .. occupancy-1]; no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            meta_reg[i]     <= meta_next[i];
            src1_tag_reg[i] <= src1_tag_next[i];
            src2_tag_reg[i] <= src2_tag_next[i];
            dst_tag_reg[i]  <= dst_tag_next[i];
            payload_reg[i]  <= payload_next[i];
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign issue_ctrl     = meta_reg[issue_idx].ctrl;
    assign issue_src1_tag = src1_tag_reg[issue_idx];
    assign issue_src2_tag = src2_tag_reg[issue_idx];
    assign issue_dst_tag  = dst_tag_reg[issue_idx];
    assign issue_payload  = payload_reg[issue_idx];
    assign occupancy      = occ_reg;

    // ------------------------------------------------------------------
    // Occupancy invariants.
    // ------------------------------------------------------------------
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occ_reg <= OCC_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        issue_fire |-> (occ_reg != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        disp_fire |-> (occ_reg < OCC_W'(DEPTH)));

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Collapsing reservation station between the decode/control stage and the integer ALU/AGU in the out-of-order core.
- Buffers decoded micro-ops with their control bundle and captures operand readiness by snooping the common data bus (CDB).
- Each cycle it issues the oldest micro-op whose needed sources are ready.
- Flushes on branch mispredict.

Parameters:
- DEPTH, 8, number of entries (power of two not required, ≥2)
- TAG_W, 6, physical register tag width; tag 0 is hard-wired x0
- PAY_W, 64, opaque payload width ({pc[31:0], imm[31:0]})

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept (= occupancy < DEPTH)
- disp_ctrl  in  8  {branch, jal, alu_src1, alu_src2, alu_op[1:0], load, store}
- disp_rs1_used  in  1  source 1 needed
- disp_rs2_used  in  1  source 2 needed
- disp_src1_tag  in  TAG_W  source 1 physical tag
- disp_src1_rdy  in  1  source 1 already ready in register file
- disp_src2_tag  in  TAG_W  source 2 physical tag
- disp_src2_rdy  in  1  source 2 already ready
- disp_dst_tag  in  TAG_W  destination tag
- disp_payload  in  PAY_W  pc/imm
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag
- issue_valid  out  1  selected entry present
- issue_ready  in  1  functional unit accepts
- issue_ctrl  out  8  selected entry ctrl
- issue_src1_tag  out  TAG_W  selected entry source 1 tag
- issue_src2_tag  out  TAG_W  selected entry source 2 tag
- issue_dst_tag  out  TAG_W  selected entry destination tag
- issue_payload  out  PAY_W  selected entry payload
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- **Reset (rst_n low, async):**
  - All entry valid bits and occupancy clear to 0.
  - issue_valid = 0 and disp_ready = 1 while in reset.
  - Entry data fields are don't-care.
- **Storage:**
  - Entries [0..occupancy-1] are valid, index 0 = oldest.
  - Each entry holds ctrl, used bits, tags, rdy1, rdy2, dst, payload.
- **Source ready at capture:** rdyN = !rsN_used | disp_srcN_rdy | (disp_srcN_tag == 0) | (cdb_valid & cdb_tag == disp_srcN_tag). The same-cycle CDB is captured.
- **Wakeup:**
  - Every cycle, every valid entry with rsN_used and srcN_tag == cdb_tag (cdb_valid = 1) sets rdyN.
  - cdb_tag == 0 is ignored.
- **Select:**
  - Combinational, driven from registered state only.
  - Picks the lowest index with valid & rdy1 & rdy2.
  - issue_* present that entry; issue_valid = found & !flush.
- **Timing:**
  - Wakeup-to-issue is 1 cycle: a CDB hit at cycle t makes the entry issuable at t+1.
  - Dispatch-to-issue is at minimum 1 cycle.
- **Issue fire:**
  - issue_valid & issue_ready removes the selected entry.
  - Entries above it shift down one slot, preserving age order and keeping any wakeup applied this cycle.
  - issue_* must hold stable while issue_valid & !issue_ready, unless an older entry becomes ready. Re-selection of an older entry is allowed; the functional unit must not assume stickiness.
- **Dispatch fire:**
  - disp_valid & disp_ready writes the new entry at index occupancy, or occupancy-1 if an issue fires the same cycle.
  - disp_ready does not see a same-cycle issue free, so a full queue stalls dispatch for one cycle.
- **Occupancy:** +1 on dispatch, -1 on issue, unchanged on both or neither.
- **Flush:**
  - Dominates: next state has all entries invalid and occupancy 0.
  - Dispatch and issue in the flush cycle are discarded; issue_valid is forced 0.
- **Invariant:** occupancy never exceeds DEPTH or underflows; assertions required.

Decomposition:
- Package issue_pkg:
  - ctrl_t packed struct matching disp_ctrl bit order.
  - iq_entry_t struct.
  - Localparam for tag x0.
- Sub-module iq_select:
  - Parameterised DEPTH lowest-index-first priority encoder.
  - Inputs: request vector. Outputs: one-hot grant, index, found.

Test Plan:
- **Reset/empty:** rst_n low for 3 cycles → occupancy 0, issue_valid 0, disp_ready 1; dispatch ADD with both rdy, dst 5 → issue_valid 1 next cycle, dst 5.
- **Wakeup:** dispatch op A with src1 tag 9 not ready; cdb_valid tag 9 at cycle t → issue_valid at t+1 with A; with CDB tag 9 in the dispatch cycle itself → issuable next cycle.
- **Oldest-first:** dispatch A (waits tag 7), B (ready), C (ready) → B issues, then C; CDB 7 → A issues. Order B, C, A with occupancy 3→2→1→0.
- **Full/back-pressure:**
  - Fill 8 entries → disp_ready 0 and dispatch ignored.
  - Hold issue_ready 0 for 4 cycles → issue_* stable.
  - Issue and dispatch in the same cycle at occupancy 7 → occupancy stays 7, new entry at index 6.
- **Flush:** 5 entries with flush, disp_valid and issue_ready all high → next cycle occupancy 0, no issue handshake, dispatched op dropped.
- **x0 and unused sources:** STORE-style op with src2 tag 0 and rdy 0, and JAL with rs1/rs2_used 0 → both issue 1 cycle after dispatch, no CDB required.
